// File: rtl/reg64_pkg.sv
// Shared constants and types for the 64-bit data register byte feeder.
// Word geometry is derived from DATA_W and BYTE_W.
package reg64_pkg;

  localparam int DATA_W    = 64;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = DATA_W / BYTE_W;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);
  localparam int IDX_W     = $clog2(NUM_BYTES);

  typedef enum logic {
    COLLECT,
    HOLD
  } asm_state_t;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/reg64_byte_assembler_if.sv
// Byte stream in, packed word out, both as valid/ready handshakes.
// slave is the assembler side, master is the feeder/register side.
interface reg64_byte_assembler_if;

  import reg64_pkg::*;

  byte_t in_data;
  logic  in_valid;
  logic  in_last;
  logic  in_ready;
  word_t word_out;
  cnt_t  word_bytes;
  logic  word_valid;
  logic  word_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output word_out,
    output word_bytes,
    output word_valid,
    input  word_ready
  );

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  word_out,
    input  word_bytes,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/reg64_byte_assembler.sv
// Packs a byte stream into 64-bit words (first byte = LSB), with early
// termination on in_last and zero fill of the unused upper lanes.
module reg64_byte_assembler
  import reg64_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  reg64_byte_assembler_if.slave bus
);

  asm_state_t             state;
  byte_t [NUM_BYTES-1:0]  lane;
  cnt_t                   count;
  logic                   hold;
  logic                   in_ready;

  assign hold     = (state == HOLD);
  assign in_ready = !hold || bus.word_ready;

  // The lanes themselves are the presented word; they are only ever
  // written while collecting, so the word is frozen in HOLD.
  assign bus.in_ready   = in_ready;
  assign bus.word_valid = hold;
  assign bus.word_out   = lane;
  assign bus.word_bytes = hold ? count : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
      lane  <= '0;
      count <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (bus.in_valid) begin
            lane[count[IDX_W-1:0]] <= bus.in_data;
            count <= count + cnt_t'(1);
            if (bus.in_last || count == cnt_t'(NUM_BYTES - 1))
              state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.word_ready) begin
            lane  <= '0;
            count <= '0;
            state <= COLLECT;
            // A byte on the handoff cycle opens the next word at lane 0.
            if (bus.in_valid) begin
              lane[0] <= bus.in_data;
              count   <= cnt_t'(1);
              if (bus.in_last)
                state <= HOLD;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
